spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Converts a spike train back into numbers: the reverse direction of the LIF neurons, which turn an input current into spikes. The block counts spikes over a programmable window to give an 8-bit rate estimate. It also measures the inter-spike interval (ISI). It sits after a neuron's `spike` output (pre- or postsynaptic) and drives status outputs or STDP debug logic.

## Interface
- `CNT_W`, default 8: width of `rate_out` and `isi_out`; all saturation limits are `2^CNT_W-1`.
- `SEL_W`, default 3: width of `window_sel`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `en` input 1: run/stop. Low holds the block in IDLE.
- `spike_in` input 1: spike train, sampled as a level every cycle.
- `window_sel` input SEL_W: window length N = 2^(window_sel+4) cycles (16..2048).
- `rate_out` output CNT_W: spike count of the last completed window, saturated.
- `rate_valid` output 1: one-cycle pulse when `rate_out` updates.
- `rate_sat` output 1: the last completed window's count saturated; updated together with `rate_out`.
- `isi_out` output CNT_W: cycles between the last two spikes, saturated.
- `isi_valid` output 1: one-cycle pulse when `isi_out` updates.

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0, `seen_spike` 0.
- **States:**
  - IDLE: window counter, spike counter and ISI counter cleared; no valid pulses; `rate_out`, `rate_sat` and `isi_out` hold their values.
  - IDLE -> COUNT at the edge that samples `en`=1. `window_sel` is latched at this edge.
  - COUNT -> IDLE at any edge sampling `en`=0. The partial window is discarded (no `rate_valid`). `seen_spike` is cleared.
- **Window (COUNT):**
  - Each edge in COUNT after the entry edge is one sample.
  - Each sample with `spike_in`=1 increments the spike counter; the counter saturates at 2^CNT_W-1 and records saturation.
  - At the Nth sample:
    - `rate_out` <= count including this sample.
    - `rate_sat` <= saturation seen.
    - `rate_valid` <= 1.
    - Counters restart at 0 for the next sample.
    - `window_sel` is re-latched.
  - Windows are back-to-back with no gap sample.
  - A `window_sel` change mid-window takes effect only at the next window boundary.
- **Level semantics:** a spike held high for k cycles counts k. A 1-cycle LIF spike counts 1.
- **ISI (COUNT only):**
  - The ISI counter increments every sample and saturates at 2^CNT_W-1.
  - On a sample with `spike_in`=1:
    - If `seen_spike`=1: `isi_out` <= ISI counter + 1, saturated; `isi_valid` <= 1.
    - In all cases: the ISI counter is cleared and `seen_spike` <= 1.
  - The first spike after reset or after leaving IDLE produces no `isi_valid`.
  - ISI is independent of window boundaries.
- **Simultaneous events:** a spike on the last sample of a window counts in that window. That spike's ISI and `rate_valid` may pulse in the same cycle.

## Timing
- All outputs are registered.
- `rate_valid` and `isi_valid` are high in the cycle after the sampling edge that produced them, for exactly one cycle.
- First `rate_valid` is N+1 edges after the IDLE->COUNT edge; later ones follow every N cycles.
- ISI latency: `isi_out` is valid one cycle after the second spike's sampling edge.
- Asynchronous reset mid-window: outputs drop to 0 immediately. After release, no pulse until `en` has been sampled high and a full window has elapsed.

## Configuration
- `SPIKE_ISI_EN` defined: ISI counter, `seen_spike` and ISI outputs are implemented as described above.
- `SPIKE_ISI_EN` undefined: ISI logic is removed; `isi_out` is tied to 0 and `isi_valid` is tied to 0. Rate behaviour is unchanged.

## Test plan
- Window rate: `window_sel`=0 (N=16), `en`=1, 1-cycle spike every 4 samples starting at sample 1 -> every 16 cycles `rate_valid` pulses with `rate_out`=4, `rate_sat`=0.
- Saturation: `window_sel`=4 (N=256), `spike_in` held 1 -> `rate_out`=255, `rate_sat`=1. Next window with `spike_in`=0 -> `rate_out`=0, `rate_sat`=0.
- ISI (`SPIKE_ISI_EN` defined): spikes at samples 10, 17, 18 -> no `isi_valid` after the first spike; `isi_out`=7, then `isi_out`=1. Spikes 300 samples apart -> `isi_out`=255.
- Window change: `window_sel` 0->1 at sample 5 of a window -> that window still closes at 16 samples; the next window is 32.
- `en` dropped at sample 10 of a 16-sample window -> no `rate_valid`, `rate_out` unchanged. Re-raising `en` gives the first `rate_valid` N+1 edges later.
- Async reset asserted mid-window with `rate_out`=4 -> all outputs 0 within the reset assertion, without waiting for a clock edge. Repeat with `SPIKE_ISI_EN` undefined -> `isi_out`/`isi_valid` stay 0 throughout.

Source files
------------

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spike_rate_decoder                                            |
// | Function : Recovers numbers from a spike train: saturating spike count   |
// |            over a programmable window of 2^(window_sel+4) cycles, plus   |
// |            inter-spike interval measurement.                             |
// | Options  : SPIKE_ISI_EN - when defined, builds the ISI counter and the   |
// |            isi_out/isi_valid outputs; otherwise those outputs are 0.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spike_rate_decoder #(
   parameter int CNT_W = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             spike_in,
   input  logic [SEL_W-1:0] window_sel,
   output logic [CNT_W-1:0] rate_out,
   output logic             rate_valid,
   output logic             rate_sat,
   output logic [CNT_W-1:0] isi_out,
   output logic             isi_valid
);

   // Window counter must reach 2^(2^SEL_W - 1 + 4) - 1, the longest window.
   localparam int               c_win_w   = (1 << SEL_W) + 3;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t             r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [c_win_w-1:0] r_win_cnt;
   logic [CNT_W-1:0]   r_spk_cnt;
   logic               r_sat_flag;

   logic [c_win_w-1:0] w_win_last;
   logic               w_at_last;
   logic               w_spk_max;
   logic [CNT_W-1:0]   w_spk_next;
   logic               w_sat_next;

   // Terminal window count N-1 = 2^(r_sel+4)-1 as a mask of low ones.
   always_comb begin
      w_win_last = '0;
      for (int i = 0; i < c_win_w; i++) begin
         w_win_last[i] = (i < (int'(r_sel) + 4));
      end
   end

   assign w_at_last  = (r_win_cnt == w_win_last);
   assign w_spk_max  = (r_spk_cnt == c_cnt_max);
   assign w_spk_next = r_spk_cnt + CNT_W'(spike_in && !w_spk_max);
   // Saturation means a spike arrived while the count was already at max.
   assign w_sat_next = r_sat_flag | (spike_in & w_spk_max);

   // Run/stop state machine, window counting and registered rate outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_win_cnt  <= '0;
         r_spk_cnt  <= '0;
         r_sat_flag <= 1'b0;
         rate_out   <= '0;
         rate_sat   <= 1'b0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_win_cnt  <= '0;
               r_spk_cnt  <= '0;
               r_sat_flag <= 1'b0;
               if (en) begin
                  r_state <= COUNT;
                  r_sel   <= window_sel;
               end
            end
            COUNT: begin
               if (!en) begin
                  // Partial window is thrown away.
                  r_state    <= IDLE;
                  r_win_cnt  <= '0;
                  r_spk_cnt  <= '0;
                  r_sat_flag <= 1'b0;
               end else if (w_at_last) begin
                  rate_out   <= w_spk_next;
                  rate_sat   <= w_sat_next;
                  rate_valid <= 1'b1;
                  r_win_cnt  <= '0;
                  r_spk_cnt  <= '0;
                  r_sat_flag <= 1'b0;
                  r_sel      <= window_sel;
               end else begin
                  r_win_cnt  <= r_win_cnt + c_win_w'(1);
                  r_spk_cnt  <= w_spk_next;
                  r_sat_flag <= w_sat_next;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SPIKE_ISI_EN
   logic [CNT_W-1:0] r_isi_cnt;
   logic             r_seen_spike;
   logic             w_isi_max;

   assign w_isi_max = (r_isi_cnt == c_cnt_max);

   // Inter-spike interval: runs across window boundaries, only while sampling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_isi_cnt    <= '0;
         r_seen_spike <= 1'b0;
         isi_out      <= '0;
         isi_valid    <= 1'b0;
      end else begin
         isi_valid <= 1'b0;
         if (r_state == COUNT && en) begin
            if (spike_in) begin
               if (r_seen_spike) begin
                  isi_out   <= w_isi_max ? c_cnt_max : r_isi_cnt + CNT_W'(1);
                  isi_valid <= 1'b1;
               end
               r_isi_cnt    <= '0;
               r_seen_spike <= 1'b1;
            end else if (!w_isi_max) begin
               r_isi_cnt <= r_isi_cnt + CNT_W'(1);
            end
         end else begin
            // Idle, entry edge or stop edge: forget any earlier spike.
            r_isi_cnt    <= '0;
            r_seen_spike <= 1'b0;
         end
      end
   end
`else
   assign isi_out   = '0;
   assign isi_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spike_rate_decoder                                         |
// | Function : Self-checking bench for spike_rate_decoder. Directed cases    |
// |            plus random spike trains, every cycle compared against a      |
// |            timestamp-based reference model.                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spike_rate_decoder;

   localparam int CNT_W = 8;
   localparam int SEL_W = 3;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             spike_in;
   logic [SEL_W-1:0] window_sel;
   logic [CNT_W-1:0] rate_out;
   logic             rate_valid;
   logic             rate_sat;
   logic [CNT_W-1:0] isi_out;
   logic             isi_valid;

   int n_checks;
   int n_errors;

   // Reference model: a running flag, window length, per-window spike total
   // and absolute sample timestamps for the interval measurement.
   bit m_run;
   int m_n;
   int m_win;
   int m_spk;
   int m_idx;
   int m_last;
   bit m_seen;
   int exp_rate;
   bit exp_sat;
   bit exp_rv;
   int exp_isi;
   bit exp_iv;

   spike_rate_decoder #(
      .CNT_W(CNT_W),
      .SEL_W(SEL_W)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .spike_in  (spike_in),
      .window_sel(window_sel),
      .rate_out  (rate_out),
      .rate_valid(rate_valid),
      .rate_sat  (rate_sat),
      .isi_out   (isi_out),
      .isi_valid (isi_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_n = 16; m_win = 0; m_spk = 0; m_seen = 0;
      exp_rate = 0; exp_sat = 0; exp_rv = 0; exp_isi = 0; exp_iv = 0;
   endtask

   task automatic model_edge(input bit e, input bit s, input int sel);
      exp_rv = 0;
      exp_iv = 0;
      if (!m_run) begin
         if (e) begin
            m_run = 1; m_n = 1 << (sel + 4); m_win = 0; m_spk = 0; m_seen = 0;
         end
      end else if (!e) begin
         m_run = 0; m_seen = 0;
      end else begin
         m_idx++;
         m_win++;
         if (s) m_spk++;
`ifdef SPIKE_ISI_EN
         if (s) begin
            if (m_seen) begin
               exp_isi = (m_idx - m_last > MAXV) ? MAXV : m_idx - m_last;
               exp_iv  = 1;
            end
            m_seen = 1;
            m_last = m_idx;
         end
`endif
         if (m_win == m_n) begin
            exp_rate = (m_spk > MAXV) ? MAXV : m_spk;
            exp_sat  = (m_spk > MAXV);
            exp_rv   = 1;
            m_win = 0; m_spk = 0; m_n = 1 << (sel + 4);
         end
      end
   endtask

   task automatic compare_all();
      check_val("rate_out",   int'(rate_out),   exp_rate);
      check_val("rate_valid", int'(rate_valid), int'(exp_rv));
      check_val("rate_sat",   int'(rate_sat),   int'(exp_sat));
      check_val("isi_out",    int'(isi_out),    exp_isi);
      check_val("isi_valid",  int'(isi_valid),  int'(exp_iv));
   endtask

   task automatic step(input bit e, input bit s, input int sel);
      @(negedge clk);
      en         = e;
      spike_in   = s;
      window_sel = SEL_W'(sel);
      @(posedge clk);
      #1;
      model_edge(e, s, sel);
      compare_all();
   endtask

   initial begin
      int dens;
      int rsel;
      n_checks = 0; n_errors = 0; m_idx = 0; m_last = 0;
      rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; window_sel = '0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0);

      // 16-sample window, one spike every 4 samples starting at sample 1.
      step(1, 0, 0);
      for (int k = 1; k <= 64; k++) step(1, (k % 4) == 1, 0);
      step(0, 0, 0);

      // Saturating window of 256, then an empty window.
      step(1, 0, 4);
      for (int k = 1; k <= 256; k++) step(1, 1, 4);
      for (int k = 1; k <= 256; k++) step(1, 0, 4);
      step(0, 0, 0);

      // Intervals: spikes at samples 10, 17, 18, then one 300 samples later.
      step(1, 0, 0);
      for (int k = 1; k <= 330; k++) step(1, k == 10 || k == 17 || k == 18 || k == 318, 0);
      step(0, 0, 0);

      // window_sel change mid-window only applies at the next boundary.
      step(1, 0, 0);
      for (int k = 1; k <= 56; k++) step(1, (k % 3) == 0, (k < 5) ? 0 : 1);
      step(0, 0, 0);

      // en dropped at sample 10, then restarted.
      step(1, 0, 0);
      for (int k = 1; k <= 20; k++) step(1, (k % 2) == 0, 0);
      for (int k = 1; k <= 10; k++) step(1, 1, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      for (int k = 1; k <= 20; k++) step(1, (k % 5) == 0, 0);

      // Random spike trains with random densities, window_sel churn and stops.
      dens = 20;
      rsel = 0;
      for (int k = 0; k < 3000; k++) begin
         if ((k % 400) == 0) dens = $urandom_range(0, 100);
         if ($urandom_range(0, 9) == 0) rsel = $urandom_range(0, 2);
         step($urandom_range(0, 149) != 0, $urandom_range(0, 99) < dens, rsel);
      end
      step(0, 0, 0);

      // Asynchronous reset mid-window after a rate of 4 has been reported.
      step(1, 0, 0);
      for (int k = 1; k <= 40; k++) step(1, (k % 4) == 1, 0);
      check_val("rate_before_reset", int'(rate_out), 4);
      @(negedge clk);
      #2;
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int k = 1; k <= 36; k++) step(1, (k % 2) == 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
